dispense_sequencer: RTL

- Actuator-side responder to the coffee-machine control FSM.
- The control FSM decides *what* to serve. This block executes the dispense and returns status.
- Flow: latch a drink request (START + B1:B0), re-check supplies, then sequence the actuators AQ (heater), P (pump), PP (powder), M (mixer) through timed phases. Finish with a DONE pulse or a sticky FAULT with an error code.

---
 rtl/dispense_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dispense_sequencer.sv
// Actuator-side dispense sequencer: latches a drink request, re-checks supplies,
// then steps heater, pump, powder valve and mixer through timed phases.
module dispense_sequencer #(
    parameter int CNT_W        = 8,
    parameter int HEAT_TIMEOUT = 200,
    parameter int POUR_CYC     = 100,
    parameter int POWDER_CYC   = 40,
    parameter int MIX_CYC      = 60
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       B1,
    input  logic       B0,
    input  logic       SR,
    input  logic       SP,
    input  logic       SN,
    input  logic       A,
    input  logic       VL,
    input  logic       ACK,
    output logic       AQ,
    output logic       P,
    output logic       PP,
    output logic       M,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAULT,
    output logic [1:0] ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_HEAT, S_POUR, S_POWDER, S_MIX, S_DONE, S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] HEAT_LAST   = CNT_W'(HEAT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] POUR_LAST   = CNT_W'(POUR_CYC - 1);
    localparam logic [CNT_W-1:0] POWDER_LAST = CNT_W'(POWDER_CYC - 1);
    localparam logic [CNT_W-1:0] MIX_LAST    = CNT_W'(MIX_CYC - 1);

    localparam logic [1:0] E_CODE   = 2'b00;
    localparam logic [1:0] E_SUPPLY = 2'b01;
    localparam logic [1:0] E_HEAT   = 2'b10;
    localparam logic [1:0] E_CUP    = 2'b11;

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [1:0]         code, nxt_code;
    logic [1:0]         nxt_err;
    logic               nxt_aq, nxt_p, nxt_pp, nxt_m;
    logic               nxt_busy, nxt_done, nxt_fault;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            cnt   <= '0;
            code  <= 2'b00;
            ERR   <= 2'b00;
            AQ    <= 1'b0;
            P     <= 1'b0;
            PP    <= 1'b0;
            M     <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            FAULT <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            code  <= nxt_code;
            ERR   <= nxt_err;
            AQ    <= nxt_aq;
            P     <= nxt_p;
            PP    <= nxt_pp;
            M     <= nxt_m;
            BUSY  <= nxt_busy;
            DONE  <= nxt_done;
            FAULT <= nxt_fault;
        end
    end

    // Cup removal is tested first in every timed phase so it beats both
    // phase completion and the heat timeout.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = '0;
        nxt_code  = code;
        nxt_err   = ERR;
        case (state)
            S_IDLE: begin
                if (START) begin
                    nxt_code  = {B1, B0};
                    nxt_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (code == 2'b00) begin
                    nxt_state = S_FAULT;
                    nxt_err   = E_CODE;
                end else if (!SR || !SN || !A || (code != 2'b01 && !SP)) begin
                    nxt_state = S_FAULT;
                    nxt_err   = E_SUPPLY;
                end else begin
                    nxt_state = S_HEAT;
                end
            end
            S_HEAT: begin
                nxt_cnt = cnt + CNT_W'(1);
                if (!A) begin
                    nxt_state = S_FAULT;
                    nxt_err   = E_CUP;
                end else if (VL) begin
                    nxt_state = S_POUR;
                end else if (cnt == HEAT_LAST) begin
                    nxt_state = S_FAULT;
                    nxt_err   = E_HEAT;
                end
            end
            S_POUR: begin
                nxt_cnt = cnt + CNT_W'(1);
                if (!A) begin
                    nxt_state = S_FAULT;
                    nxt_err   = E_CUP;
                end else if (cnt == POUR_LAST) begin
                    nxt_state = (code == 2'b01) ? S_DONE : S_POWDER;
                end
            end
            S_POWDER: begin
                nxt_cnt = cnt + CNT_W'(1);
                if (!A) begin
                    nxt_state = S_FAULT;
                    nxt_err   = E_CUP;
                end else if (cnt == POWDER_LAST) begin
                    nxt_state = (code == 2'b10) ? S_DONE : S_MIX;
                end
            end
            S_MIX: begin
                nxt_cnt = cnt + CNT_W'(1);
                if (!A) begin
                    nxt_state = S_FAULT;
                    nxt_err   = E_CUP;
                end else if (cnt == MIX_LAST) begin
                    nxt_state = S_DONE;
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
            end
            S_FAULT: begin
                if (ACK) begin
                    nxt_state = S_IDLE;
                    nxt_err   = 2'b00;
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
        if (nxt_state != state) begin
            nxt_cnt = '0;
        end
    end

    // Outputs are decoded from the next state and registered, so each
    // actuator rises on exactly the edge its predecessor falls.
    always_comb begin
        nxt_aq    = (nxt_state == S_HEAT);
        nxt_p     = (nxt_state == S_POUR);
        nxt_pp    = (nxt_state == S_POWDER);
        nxt_m     = (nxt_state == S_MIX);
        nxt_busy  = !(nxt_state == S_IDLE || nxt_state == S_FAULT);
        nxt_done  = (nxt_state == S_DONE);
        nxt_fault = (nxt_state == S_FAULT);
    end

endmodule
